// File: rtl/avst_pkt_sink_if.sv
// Valid/ready/end streaming link between a beat source (master) and a sink (slave).
interface avst_pkt_sink_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              end_in;
  logic              valid_in;
  logic              ready_in;

  modport master (
    output data_in,
    output end_in,
    output valid_in,
    input  ready_in
  );

  modport slave (
    input  data_in,
    input  end_in,
    input  valid_in,
    output ready_in
  );
endinterface

// File: rtl/avst_pkt_sink.sv
// Streaming packet sink: show-ahead beat FIFO plus per-packet length/checksum reporting.
module avst_pkt_sink #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  avst_pkt_sink_if.slave           st,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_end,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     pkt_done,
  output logic [7:0]               pkt_len,
  output logic [7:0]               pkt_sum,
  output logic                     pkt_len_err,
  output logic [CNT_W-1:0]         pkt_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LvlFull = DEPTH[AW:0];

  typedef enum logic {StIdle, StInPkt} state_e;

  logic [DATA_W:0]   mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;
  logic [DATA_W:0]   hold_q, head;
  logic              push, pop;

  state_e            state_q, state_d;
  logic [7:0]        len_q, len_d, sum_q, sum_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d, err_q, err_d;
  logic [7:0]        out_len_q, out_len_d, out_sum_q, out_sum_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        len_base, sum_base, len_inc, sum_inc;
  logic              ovf_base, ovf_inc;

  assign st.ready_in = !reset && (level_q != LvlFull);
  assign push        = st.valid_in && st.ready_in;
  assign empty       = (level_q == '0);
  assign pop         = rd_en && !empty;
  // While empty the head shows the last value seen rather than a stale slot.
  assign head        = empty ? hold_q : mem_q[rd_ptr_q];
  assign rd_data     = head[DATA_W-1:0];
  assign rd_end      = head[DATA_W];
  assign level       = level_q;

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {st.end_in, st.data_in};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      hold_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
      hold_q <= head;
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    sum_d     = sum_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;
    out_len_d = out_len_q;
    out_sum_d = out_sum_q;
    err_d     = err_q;
    cnt_d     = cnt_q;

    len_base = (state_q == StIdle) ? 8'd0 : len_q;
    sum_base = (state_q == StIdle) ? 8'd0 : sum_q;
    ovf_base = (state_q == StIdle) ? 1'b0 : ovf_q;
    len_inc  = (len_base == 8'hFF) ? 8'hFF : len_base + 8'd1;
    ovf_inc  = ovf_base | (len_base == 8'hFF);
    sum_inc  = sum_base + 8'(st.data_in);

    if (push) begin
      if (st.end_in) begin
        done_d    = 1'b1;
        out_len_d = len_inc;
        out_sum_d = sum_inc;
        err_d     = ovf_inc;
        cnt_d     = cnt_q + CNT_W'(1);
        state_d   = StIdle;
        len_d     = 8'd0;
        sum_d     = 8'd0;
        ovf_d     = 1'b0;
      end else begin
        state_d = StInPkt;
        len_d   = len_inc;
        sum_d   = sum_inc;
        ovf_d   = ovf_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      len_q     <= '0;
      sum_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      out_len_q <= '0;
      out_sum_q <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      sum_q     <= sum_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      out_len_q <= out_len_d;
      out_sum_q <= out_sum_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pkt_done    = done_q;
  assign pkt_len     = out_len_q;
  assign pkt_sum     = out_sum_q;
  assign pkt_len_err = err_q;
  assign pkt_count   = cnt_q;
endmodule

// File: tb/tb_avst_pkt_sink.sv
// Random and directed stimulus against a queue/integer model of the packet sink.
module tb_avst_pkt_sink;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_end;
  logic       empty;
  logic [4:0] level;
  logic       pkt_done;
  logic [7:0] pkt_len;
  logic [7:0] pkt_sum;
  logic       pkt_len_err;
  logic [15:0] pkt_count;

  avst_pkt_sink_if #(.DATA_W(8)) st_if ();

  avst_pkt_sink #(.DATA_W(8), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (rst),
    .st          (st_if.slave),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_end      (rd_end),
    .empty       (empty),
    .level       (level),
    .pkt_done    (pkt_done),
    .pkt_len     (pkt_len),
    .pkt_sum     (pkt_sum),
    .pkt_len_err (pkt_len_err),
    .pkt_count   (pkt_count)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference model state
  logic [8:0] q [$];
  logic [8:0] last_head = '0;
  int         run_len = 0;
  int         run_sum = 0;
  int         pkt_cnt = 0;
  bit         exp_done = 0;
  int         exp_len = 0;
  int         exp_sum = 0;
  bit         exp_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic e, input logic rd,
                      input logic rs, output logic acc);
    bit exp_ready;
    rst = rs;
    st_if.valid_in = v;
    st_if.data_in  = d;
    st_if.end_in   = e;
    rd_en          = rd;
    #1;
    exp_ready = !rs && (q.size() != DEPTH);
    check("ready_in", {31'd0, st_if.ready_in}, {31'd0, exp_ready});
    acc = v && exp_ready;
    exp_done = 0;
    if (rs) begin
      q.delete();
      last_head = '0;
      run_len = 0; run_sum = 0; pkt_cnt = 0;
      exp_len = 0; exp_sum = 0; exp_err = 0;
    end else begin
      if (rd && q.size() > 0) void'(q.pop_front());
      if (acc) begin
        q.push_back({e, d});
        run_len++;
        run_sum += int'(d);
        if (e) begin
          exp_done = 1;
          exp_len  = (run_len > 255) ? 255 : run_len;
          exp_sum  = run_sum % 256;
          exp_err  = (run_len > 255);
          pkt_cnt++;
          run_len = 0;
          run_sum = 0;
        end
      end
    end
    if (q.size() > 0) last_head = q[0];
    @(posedge clk);
    #1;
    check("empty",    {31'd0, empty},    {31'd0, q.size() == 0});
    check("level",    {27'd0, level},    q.size());
    check("rd_data",  {24'd0, rd_data},  {24'd0, last_head[7:0]});
    check("rd_end",   {31'd0, rd_end},   {31'd0, last_head[8]});
    check("pkt_done", {31'd0, pkt_done}, {31'd0, exp_done});
    check("pkt_len",  {24'd0, pkt_len},  exp_len);
    check("pkt_sum",  {24'd0, pkt_sum},  exp_sum);
    check("pkt_err",  {31'd0, pkt_len_err}, {31'd0, exp_err});
    check("pkt_count", {16'd0, pkt_count}, pkt_cnt & 32'hFFFF);
  endtask

  initial begin
    logic        acc;
    logic        v, e, rd, rs;
    logic [7:0]  d;
    bit          pend;
    int          rd_bias;

    rst = 1'b1; rd_en = 1'b0;
    st_if.valid_in = 1'b0; st_if.data_in = '0; st_if.end_in = 1'b0;

    // Reset, then idle
    step(0, 8'h00, 0, 0, 1, acc);
    step(0, 8'h00, 0, 0, 1, acc);
    step(0, 8'h00, 0, 0, 0, acc);

    // Three-beat packet with continuous drain
    step(1, 8'h01, 0, 1, 0, acc);
    step(1, 8'h02, 0, 1, 0, acc);
    step(1, 8'h03, 1, 1, 0, acc);
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1, 0, acc);

    // Fill to full, hold a beat under backpressure, release with one pop
    for (int i = 0; i < 16; i++) step(1, 8'(8'h10 + i), 0, 0, 0, acc);
    step(1, 8'h20, 0, 0, 0, acc);
    step(1, 8'h20, 0, 0, 0, acc);
    step(1, 8'h20, 0, 1, 0, acc);
    step(1, 8'h20, 0, 0, 0, acc);
    step(0, 8'h00, 0, 1, 0, acc);
    step(0, 8'h00, 0, 1, 0, acc);
    step(1, 8'h21, 1, 1, 0, acc);
    for (int i = 0; i < 20; i++) step(0, 8'h00, 0, 1, 0, acc);

    // Checksum wrap and a single-beat packet
    step(1, 8'hFF, 0, 1, 0, acc);
    step(1, 8'hFF, 0, 1, 0, acc);
    step(1, 8'h03, 1, 1, 0, acc);
    step(1, 8'h7A, 1, 1, 0, acc);
    step(0, 8'h00, 0, 1, 0, acc);

    // Length saturation, then a short packet clears the error
    for (int i = 0; i < 300; i++) step(1, 8'h01, (i == 299), 1, 0, acc);
    step(1, 8'h11, 0, 1, 0, acc);
    step(1, 8'h22, 1, 1, 0, acc);
    step(0, 8'h00, 0, 1, 0, acc);

    // Reset mid-packet discards everything
    for (int i = 0; i < 5; i++) step(1, 8'(8'h40 + i), 0, 0, 0, acc);
    step(1, 8'h99, 1, 0, 1, acc);
    step(0, 8'h00, 0, 0, 0, acc);
    step(1, 8'h04, 0, 0, 0, acc);
    step(1, 8'h05, 1, 0, 0, acc);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 1, 0, acc);

    // Random traffic; the source holds a beat until it is taken
    pend = 0; v = 0; d = '0; e = 0; rd_bias = 60;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) rd_bias = (i % 1500 == 0) ? 20 : ((i % 1000 == 0) ? 95 : 55);
      if (!pend) begin
        v = ($urandom % 4) != 0;
        d = 8'($urandom);
        e = ($urandom % 8) == 0;
      end
      rd = ($urandom % 100) < rd_bias;
      rs = ($urandom % 700) == 0;
      step(v, d, e, rd, rs, acc);
      pend = v && !acc && !rs;
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/avst_pkt_sink.md
Name: avst_pkt_sink

Overview:
Avalon-ST packet sink. It is the consumer end of the 8-bit valid/ready/end streaming interface driven by stream sources such as adder_avst. Accepted beats are buffered in a show-ahead FIFO that a downstream reader drains with a pop strobe. Per-packet length and mod-256 checksum are computed on the fly and reported with a one-cycle done pulse. Used as the standard stream terminator and checker for streaming blocks.

Parameters:
DATA_W, 8, stream data width.
DEPTH, 16, FIFO depth in beats; power of two, at least 2.
CNT_W, 16, width of the packet counter.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  DATA_W  stream data beat.
end_in  input  1  marks last beat of a packet.
valid_in  input  1  source has a beat on data_in/end_in.
ready_in  output  1  sink can accept a beat this cycle.
rd_en  input  1  pop head entry of FIFO.
rd_data  output  DATA_W  FIFO head data (show-ahead).
rd_end  output  1  FIFO head end flag.
empty  output  1  FIFO holds no entries.
level  output  log2(DEPTH)+1  current FIFO occupancy.
pkt_done  output  1  one-cycle pulse: a packet end beat was accepted last cycle.
pkt_len  output  8  beat count of the completed packet, saturating at 255.
pkt_sum  output  8  mod-256 sum of all data bytes of the completed packet.
pkt_len_err  output  1  completed packet exceeded 255 beats; valid with pkt_done.
pkt_count  output  CNT_W  number of completed packets, wraps at 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values: FIFO empty, level=0, empty=1, rd_data=0, rd_end=0, pkt_done=0, pkt_len=0, pkt_sum=0, pkt_len_err=0, pkt_count=0. Internal running length and sum are 0.
- ready_in = !reset && (level != DEPTH). It is combinational from registered state and does not depend on valid_in.
- Accept: a beat is accepted on a rising edge where valid_in && ready_in. Ready latency is 0. If valid_in is high while ready_in is low, the beat is not taken and the source must hold it.
- Push: an accepted beat writes {end_in, data_in} at the write pointer. Write pointer wraps modulo DEPTH.
- Pop: on rd_en && !empty, the read pointer advances. rd_en while empty is ignored and causes no underflow or state change.
- Show-ahead read: rd_data/rd_end reflect the head entry whenever empty=0. They hold their last value when empty=1.
- Write-to-read latency: a beat pushed at edge N appears on rd_data after edge N, so empty falls in the same cycle.
- level update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- Full with pop: when level=DEPTH, no push can occur. A pop at full lowers level, so ready_in rises in the next cycle.
- Empty with push and rd_en: the push proceeds and the pop is ignored. level goes from 0 to 1.
- Packet accounting state machine, states IDLE and IN_PKT:
  - IDLE → IN_PKT on an accepted beat with end_in=0. Running length=1, running sum=data_in.
  - IN_PKT stays on accepted non-end beats. Length increments, saturating at 255, and sets an overflow flag when an increment would exceed 255. Sum adds data_in mod 256.
  - Any accepted beat with end_in=1, from either state, finalises the packet:
    - Next cycle: pkt_done=1.
    - pkt_len = running length including this beat, saturated.
    - pkt_sum = running sum plus this data_in, mod 256.
    - pkt_len_err = overflow flag.
    - pkt_count increments.
    - State returns to IDLE and running length, sum and flag clear.
  - A single beat with end_in=1 in IDLE is a 1-beat packet.
- pkt_len, pkt_sum and pkt_len_err hold their values until the next pkt_done.
- Packet accounting is independent of the reader: done is reported on acceptance, not on pop.
- Reset mid-packet discards the partial packet and all FIFO contents. pkt_done does not assert for the discarded packet.
- Simultaneous end-beat acceptance and reset: reset wins.

Test Plan:
- Reset then idle: reset high for 2 cycles → all outputs at reset values; ready_in=1 after reset falls, empty=1, level=0.
- Single packet with continuous drain: send 0x01,0x02,0x03 (end on 0x03) with rd_en=1 → pkt_done one cycle after end beat, pkt_len=3, pkt_sum=0x06, pkt_count=1; rd_data sequence 01,02,03 with rd_end=1 on 03.
- Backpressure, DEPTH=16, rd_en=0: push 16 beats 0x10..0x1F with no end → ready_in=0 after the 16th beat, level=16, a held 17th beat is not accepted. Then assert rd_en one cycle → level=15, ready_in=1, the held beat is accepted.
- Wrap and checksum: packet of 0xFF,0xFF,0x03 (end) → pkt_sum=0x01, pkt_len=3. Then a 1-beat packet 0x7A with end → pkt_len=1, pkt_sum=0x7A, pkt_count=2.
- Length saturation: a 300-beat packet of 0x01 → pkt_len=255, pkt_len_err=1, pkt_sum=0x2C (300 mod 256). The next 2-beat packet reports pkt_len_err=0.
- Reset mid-packet: accept 5 beats without end, then assert reset 1 cycle → no pkt_done, empty=1, level=0, pkt_count unchanged at 0. A following 2-beat packet 0x04,0x05 reports pkt_len=2, pkt_sum=0x09.
